// File: rtl/ber_ctrl_pkg.sv
// Shared types and helpers for the BER phase-scan controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ber_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST_BER = 3'd1,
        ST_SYNC    = 3'd2,
        ST_MEAS    = 3'd3,
        ST_EVAL    = 3'd4,
        ST_LOCK    = 3'd5
    } scan_state_t;

    // Width of a strobe counter that must reach max(a,b) without wrapping.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    // Index width for n items; at least one bit so ports never collapse.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ber_min_tracker.sv
// Registered strict-minimum tracker: keeps the smallest value loaded and the index it came with.
// Latency: 1 cycle from i_load to o_min_*; o_min_idx_nxt shows the value about to be registered.
// Backpressure: none; i_clear wins over i_load.
// Ports: clk/i_rst (sync, active-high); i_clear resets to all-ones/0; i_load with i_val/i_idx
//        offers a candidate; o_min_val/o_min_idx are the registered result.
module ber_min_tracker #(
    parameter int VW = 64,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [VW-1:0] i_val,
    input  logic [IW-1:0] i_idx,
    output logic [VW-1:0] o_min_val,
    output logic [IW-1:0] o_min_idx,
    output logic [IW-1:0] o_min_idx_nxt
);

    logic [VW-1:0] min_val_d, min_val_q;
    logic [IW-1:0] min_idx_d, min_idx_q;

    always_comb begin
        min_val_d = min_val_q;
        min_idx_d = min_idx_q;
        if (i_clear) begin
            min_val_d = '1;
            min_idx_d = '0;
        end else if (i_load && (i_val < min_val_q)) begin
            // Strict compare: on a tie the earlier (lower) index is kept.
            min_val_d = i_val;
            min_idx_d = i_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            min_val_q <= '1;
            min_idx_q <= '0;
        end else begin
            min_val_q <= min_val_d;
            min_idx_q <= min_idx_d;
        end
    end

    assign o_min_val     = min_val_q;
    assign o_min_idx     = min_idx_q;
    assign o_min_idx_nxt = min_idx_d;

endmodule

// File: rtl/ber_phase_scan_ctrl.sv
// Scans every receive sampling phase with the BER checker and locks onto the lowest-error phase.
// Latency: N_PHASES*(SYNC_LEN+MEAS_LEN+2) cycles from i_start to o_done with i_valid held high.
// Backpressure: i_valid low stalls the SYNC/MEAS strobe counters; RST_BER and EVAL never wait.
// Ports: clk/i_rst (sync, active-high); i_start/i_abort control pulses; i_valid symbol strobe;
//        i_ber_samp/i_ber_err checker counters; o_ber_rst/o_ber_en/o_phase_sel drive the checker;
//        o_best_phase/o_best_err result; o_busy while scanning; o_done pulse on lock.
// Option BER_SCAN_LOG_EN: per-phase error log readable through i_log_idx/o_log_err.
module ber_phase_scan_ctrl
    import ber_ctrl_pkg::*;
#(
    parameter int N_PHASES = 4,
    parameter int NB_CNT   = 64,
    parameter int SYNC_LEN = 261121,
    parameter int MEAS_LEN = 1024,
    localparam int PW = idx_width(N_PHASES),
    localparam int CW = cnt_width(SYNC_LEN, MEAS_LEN)
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_valid,
    input  logic [NB_CNT-1:0] i_ber_samp,
    input  logic [NB_CNT-1:0] i_ber_err,
    output logic              o_ber_rst,
    output logic              o_ber_en,
    output logic [PW-1:0]     o_phase_sel,
    output logic [PW-1:0]     o_best_phase,
    output logic [NB_CNT-1:0] o_best_err,
    output logic              o_busy,
    output logic              o_done
`ifdef BER_SCAN_LOG_EN
    ,
    input  logic [PW-1:0]     i_log_idx,
    output logic [NB_CNT-1:0] o_log_err
`endif
);

    localparam logic [CW-1:0] SYNC_LAST  = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] MEAS_LAST  = CW'(MEAS_LEN - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

    scan_state_t       state_d, state_q;
    logic [PW-1:0]     phase_idx_d, phase_idx_q;
    logic [CW-1:0]     cnt_d, cnt_q;
    logic [NB_CNT-1:0] err0_d, err0_q;
    logic              ber_rst_d, ber_rst_q;
    logic              ber_en_d, ber_en_q;
    logic [PW-1:0]     phase_sel_d, phase_sel_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;

    logic              start_ok;
    logic              trk_clear, trk_load;
    logic [NB_CNT-1:0] meas_err;
    logic [PW-1:0]     best_idx_nxt;

    // The window length is counted locally on i_valid, so the checker's sample count is not needed.
    logic unused_samp;
    assign unused_samp = ^i_ber_samp;

    assign start_ok = i_start && ((state_q == ST_IDLE) || (state_q == ST_LOCK));
    // Modular difference tolerates the checker's error counter wrapping inside the window.
    assign meas_err = i_ber_err - err0_q;

    always_comb begin : next_state
        state_d     = state_q;
        phase_idx_d = phase_idx_q;
        cnt_d       = cnt_q;
        err0_d      = err0_q;
        trk_clear   = 1'b0;
        trk_load    = 1'b0;
        if (i_abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (start_ok) begin
            state_d     = ST_RST_BER;
            phase_idx_d = '0;
            cnt_d       = '0;
            trk_clear   = 1'b1;
        end else begin
            case (state_q)
                ST_RST_BER: state_d = ST_SYNC;
                ST_SYNC: begin
                    if (i_valid) begin
                        if (cnt_q == SYNC_LAST) begin
                            state_d = ST_MEAS;
                            cnt_d   = '0;
                            err0_d  = i_ber_err;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_MEAS: begin
                    if (i_valid) begin
                        if (cnt_q == MEAS_LAST) begin
                            state_d = ST_EVAL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_EVAL: begin
                    trk_load = 1'b1;
                    if (phase_idx_q == LAST_PHASE) begin
                        state_d = ST_LOCK;
                    end else begin
                        phase_idx_d = phase_idx_q + PW'(1);
                        state_d     = ST_RST_BER;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin : out_next
        ber_rst_d   = 1'b0;
        ber_en_d    = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        phase_sel_d = phase_sel_q;
        case (state_d)
            ST_RST_BER: begin
                ber_rst_d   = 1'b1;
                busy_d      = 1'b1;
                phase_sel_d = phase_idx_d;
            end
            ST_SYNC, ST_MEAS, ST_EVAL: begin
                ber_en_d = 1'b1;
                busy_d   = 1'b1;
            end
            ST_LOCK: begin
                if (state_q != ST_LOCK) begin
                    // First lock cycle re-syncs the checker on the winner; the tracker is
                    // updating on this same edge, so take its next-state index.
                    ber_rst_d   = 1'b1;
                    done_d      = 1'b1;
                    phase_sel_d = best_idx_nxt;
                end else begin
                    ber_en_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            phase_idx_q <= '0;
            cnt_q       <= '0;
            err0_q      <= '0;
            ber_rst_q   <= 1'b0;
            ber_en_q    <= 1'b0;
            phase_sel_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_idx_q <= phase_idx_d;
            cnt_q       <= cnt_d;
            err0_q      <= err0_d;
            ber_rst_q   <= ber_rst_d;
            ber_en_q    <= ber_en_d;
            phase_sel_q <= phase_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    ber_min_tracker #(
        .VW (NB_CNT),
        .IW (PW)
    ) u_min_tracker (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_clear       (trk_clear),
        .i_load        (trk_load),
        .i_val         (meas_err),
        .i_idx         (phase_idx_q),
        .o_min_val     (o_best_err),
        .o_min_idx     (o_best_phase),
        .o_min_idx_nxt (best_idx_nxt)
    );

    assign o_ber_rst   = ber_rst_q;
    assign o_ber_en    = ber_en_q;
    assign o_phase_sel = phase_sel_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

`ifdef BER_SCAN_LOG_EN
    logic [NB_CNT-1:0] log_d [N_PHASES];
    logic [NB_CNT-1:0] log_q [N_PHASES];

    always_comb begin
        log_d = log_q;
        if (trk_clear) begin
            for (int p = 0; p < N_PHASES; p++) log_d[p] = '0;
        end else if (trk_load) begin
            log_d[phase_idx_q] = meas_err;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int p = 0; p < N_PHASES; p++) log_q[p] <= '0;
        end else begin
            log_q <= log_d;
        end
    end

    assign o_log_err = (int'(i_log_idx) < N_PHASES) ? log_q[i_log_idx] : '0;
`endif

endmodule
